// File: rtl/edge_strip_sequencer_if.sv
// Pixel-in / packed-flag-out bus of the edge strip sequencer; master is the upstream/downstream side, slave is the sequencer.
// EDGE_SEQ_STATS_EN adds the edge_count status signal.
interface edge_strip_sequencer_if;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        frame_start;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [9:0]  out_row;
    logic        frame_done;
`ifdef EDGE_SEQ_STATS_EN
    logic [19:0] edge_count;
`endif

    modport master (
`ifdef EDGE_SEQ_STATS_EN
        input  edge_count,
`endif
        output pixel_in, pixel_valid, frame_start, out_ready,
        input  pixel_ready, out_data, out_valid, out_last, out_row, frame_done
    );

    modport slave (
`ifdef EDGE_SEQ_STATS_EN
        output edge_count,
`endif
        input  pixel_in, pixel_valid, frame_start, out_ready,
        output pixel_ready, out_data, out_valid, out_last, out_row, frame_done
    );
endinterface

// File: rtl/edge_strip_sequencer.sv
// Edge strip sequencer: 3-line rotating store, cross-kernel thresholding one column/cycle, 16 columns per 32-bit word; first word 17 cycles after row 2 ends.
// pixel_ready/out_valid are registered; out_ready=0 holds the column counter on a word boundary. EDGE_SEQ_STATS_EN adds edge_count.
module edge_strip_sequencer #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                  clock,
    input  logic                  reset,
    edge_strip_sequencer_if.slave bus
);
    localparam int CW = $clog2(LINE_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [9:0]    ROW_LAST = 10'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_SOF, FILL, PROCESS, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [9:0]      row_q, row_d;
    logic [1:0]      slot_q, slot_d;
    logic [29:0]     acc_q, acc_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [9:0]      out_row_q, out_row_d;
    logic            frame_done_q, frame_done_d;
    logic            pixel_ready_q, pixel_ready_d;

    logic [7:0]      line_mem [3][LINE_WIDTH];
    logic            wr_en;
    logic [1:0]      wr_slot;
    logic [CW-1:0]   wr_col;

    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // slot_q holds row r's slot (the "down" line) while processing, so up = r+1 = r-2 mod 3
    logic [1:0]      up_slot, ctr_slot;
    logic [CW-1:0]   col_rt, col_lf;
    logic [7:0]      pix_up, pix_dn, pix_rt, pix_lf;
    logic signed [8:0] dx, dy;
    logic            edge_col, thdx, thdy;

    always_comb begin
        up_slot  = slot_inc(slot_q);
        ctr_slot = slot_inc(up_slot);
        col_rt   = (col_q == COL_LAST) ? col_q : col_q + CW'(1);
        col_lf   = (col_q == '0) ? col_q : col_q - CW'(1);
        pix_up   = line_mem[up_slot][col_q];
        pix_dn   = line_mem[slot_q][col_q];
        pix_rt   = line_mem[ctr_slot][col_rt];
        pix_lf   = line_mem[ctr_slot][col_lf];
        dx       = $signed({1'b0, pix_rt}) - $signed({1'b0, pix_lf});
        dy       = $signed({1'b0, pix_dn}) - $signed({1'b0, pix_up});
        edge_col = (col_q == '0) || (col_q == COL_LAST);
        thdx     = !edge_col && ((dx >= 9'sd32) || (dx <= -9'sd33));
        thdy     = !edge_col && ((dy >= 9'sd32) || (dy <= -9'sd33));
    end

    logic accept, word_end, col_step;
    assign accept   = bus.pixel_valid && pixel_ready_q;
    assign word_end = (col_q[3:0] == 4'hF);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        slot_d       = slot_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_row_d    = out_row_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        wr_slot      = slot_q;
        wr_col       = col_q;
        col_step     = 1'b0;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        unique case (state_q)
            WAIT_SOF, FILL: begin
                if (accept && bus.frame_start) begin
                    wr_en   = 1'b1;
                    wr_slot = 2'd0;
                    wr_col  = '0;
                    col_d   = CW'(1);
                    row_d   = '0;
                    slot_d  = 2'd0;
                    state_d = FILL;
                end else if (accept && state_q == FILL) begin
                    wr_en = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q >= 10'd2) begin
                            state_d = PROCESS;
                        end else begin
                            row_d  = row_q + 10'd1;
                            slot_d = slot_inc(slot_q);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            PROCESS: begin
                // a finished word may only replace the output register once it is free or leaving
                if (!word_end || !out_valid_q || bus.out_ready) begin
                    col_step = 1'b1;
                    acc_d    = {thdy, thdx, acc_q[29:2]};
                    if (word_end) begin
                        out_data_d  = {thdy, thdx, acc_q};
                        out_valid_d = 1'b1;
                        out_last_d  = (col_q == COL_LAST);
                        out_row_d   = row_q - 10'd1;
                    end
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (row_q == ROW_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = WAIT_SOF;
                    end else begin
                        row_d   = row_q + 10'd1;
                        slot_d  = slot_inc(slot_q);
                        state_d = FILL;
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase

        pixel_ready_d = (state_d == WAIT_SOF) || (state_d == FILL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= WAIT_SOF;
            col_q         <= '0;
            row_q         <= '0;
            slot_q        <= '0;
            acc_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_row_q     <= '0;
            frame_done_q  <= 1'b0;
            pixel_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            slot_q        <= slot_d;
            acc_q         <= acc_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_row_q     <= out_row_d;
            frame_done_q  <= frame_done_d;
            pixel_ready_q <= pixel_ready_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) line_mem[wr_slot][wr_col] <= bus.pixel_in;
    end

`ifdef EDGE_SEQ_STATS_EN
    // only counts while processing, so it naturally freezes once frame_done fires
    logic [19:0] edge_count_q, edge_count_d;
    always_comb begin
        edge_count_d = edge_count_q;
        if (accept && bus.frame_start)
            edge_count_d = '0;
        else if (col_step && (thdx || thdy) && (edge_count_q != 20'hFFFFF))
            edge_count_d = edge_count_q + 20'd1;
    end
    always_ff @(posedge clock) begin
        if (reset) edge_count_q <= '0;
        else       edge_count_q <= edge_count_d;
    end
    assign bus.edge_count = edge_count_q;
`endif

    assign bus.pixel_ready = pixel_ready_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_row     = out_row_q;
    assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_edge_strip_sequencer.sv
// Scoreboard bench for edge_strip_sequencer at LINE_WIDTH=32, FRAME_HEIGHT=4 with directed frames.
module tb_edge_strip_sequencer;
    localparam int LW = 32;
    localparam int FH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_strip_sequencer_if bus();
    edge_strip_sequencer #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [9:0]  row;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fd_cnt   = 0;
    int exp_fd   = 0;
    int t_acc    = 0;
    int exp_edges = 0;
    bit lat_armed = 1'b0;
    bit bp_seen, bp_stable, bp_prlow;
    logic [31:0] bp_d0;
    logic        bp_l0;
    logic [9:0]  bp_r0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && lat_armed) begin
                chk("first_word_latency", 32'(cyc - t_acc), 32'd17);
                lat_armed = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got 0x%0h row %0d, expected no word", bus.out_data, bus.out_row);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("word_data", bus.out_data, mon_e.data);
                    chk("word_last", 32'(bus.out_last), 32'(mon_e.last));
                    chk("word_row",  32'(bus.out_row),  32'(mon_e.row));
                end
            end
            if (bus.frame_done) begin
                fd_cnt++;
`ifdef EDGE_SEQ_STATS_EN
                chk("edge_count_at_frame_done", 32'(bus.edge_count), 32'(exp_edges));
`endif
            end
        end
    end

    task automatic push_pixel(input logic [7:0] p, input logic sof, output bit ok, output int t);
        bus.pixel_in    = p;
        bus.pixel_valid = 1'b1;
        bus.frame_start = sof;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.pixel_ready) begin
                ok = 1'b1;
                t  = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL pixel_accept_timeout: got no pixel_ready, expected acceptance within 2000 cycles");
        end
    endtask

    // raster-order pixels; vstep selects the column step, otherwise rows 0-1 = top, rows 2-3 = bot
    task automatic send_rows(input logic [7:0] top, input logic [7:0] bot, input bit vstep,
                             input int npix, input bit sof_en, input bit meas);
        bit ok;
        int t;
        logic [7:0] p;
        for (int idx = 0; idx < npix; idx++) begin
            if (vstep) p = ((idx % LW) < 16) ? 8'h10 : 8'h60;
            else       p = ((idx / LW) < 2) ? top : bot;
            push_pixel(p, sof_en && (idx == 0), ok, t);
            if (!ok) return;
            if (meas && idx == 3 * LW - 1) begin
                t_acc     = t;
                lat_armed = 1'b1;
            end
        end
    endtask

    task automatic expect_frame(input logic [31:0] w0, input logic [31:0] w1);
        sbq.push_back('{data: w0, last: 1'b0, row: 10'd1});
        sbq.push_back('{data: w1, last: 1'b1, row: 10'd1});
        sbq.push_back('{data: w0, last: 1'b0, row: 10'd2});
        sbq.push_back('{data: w1, last: 1'b1, row: 10'd2});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 500 && sbq.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_words_left"}, 32'(sbq.size()), 32'd0);
        chk({name, "_frame_done_count"}, 32'(fd_cnt), 32'(exp_fd));
    endtask

    task automatic run_frame(input string name, input logic [7:0] top, input logic [7:0] bot,
                             input bit vstep, input logic [31:0] w0, input logic [31:0] w1,
                             input int edges, input bit meas);
        exp_edges = edges;
        expect_frame(w0, w1);
        exp_fd++;
        send_rows(top, bot, vstep, LW * FH, 1'b1, meas);
        wait_drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion within 50000 cycles");
        $fatal(1);
    end

    initial begin
        bus.pixel_in    = 8'h00;
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.out_ready   = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pixel_ready", 32'(bus.pixel_ready), 32'd0);
        chk("reset_out_valid",   32'(bus.out_valid),   32'd0);
        chk("reset_out_data",    bus.out_data,         32'd0);
        chk("reset_out_last",    32'(bus.out_last),    32'd0);
        chk("reset_out_row",     32'(bus.out_row),     32'd0);
        chk("reset_frame_done",  32'(bus.frame_done),  32'd0);
`ifdef EDGE_SEQ_STATS_EN
        chk("reset_edge_count",  32'(bus.edge_count),  32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("pixel_ready_after_reset", 32'(bus.pixel_ready), 32'd1);

        run_frame("flat",      8'h80, 8'h80, 1'b0, 32'h0000_0000, 32'h0000_0000, 0,  1'b1);
        run_frame("vstep",     8'h00, 8'h00, 1'b1, 32'h4000_0000, 32'h0000_0001, 4,  1'b0);
        run_frame("hstep_p32", 8'h00, 8'h20, 1'b0, 32'hAAAA_AAA8, 32'h2AAA_AAAA, 60, 1'b0);
        run_frame("hstep_p31", 8'h00, 8'h1F, 1'b0, 32'h0000_0000, 32'h0000_0000, 0,  1'b0);
        run_frame("hstep_m32", 8'h20, 8'h00, 1'b0, 32'h0000_0000, 32'h0000_0000, 0,  1'b0);
        run_frame("hstep_m33", 8'h21, 8'h00, 1'b0, 32'hAAAA_AAA8, 32'h2AAA_AAAA, 60, 1'b0);

        // backpressure: first word held 20 cycles
        exp_edges = 4;
        expect_frame(32'h4000_0000, 32'h0000_0001);
        exp_fd++;
        bus.out_ready = 1'b0;
        fork
            send_rows(8'h00, 8'h00, 1'b1, LW * FH, 1'b1, 1'b0);
            begin
                bp_seen = 1'b0;
                for (int i = 0; i < 400 && !bp_seen; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) bp_seen = 1'b1;
                end
                chk("bp_word_presented", 32'(bp_seen), 32'd1);
                bp_d0 = bus.out_data;
                bp_l0 = bus.out_last;
                bp_r0 = bus.out_row;
                bp_stable = 1'b1;
                bp_prlow  = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (bus.out_data !== bp_d0 || bus.out_last !== bp_l0 ||
                        bus.out_row !== bp_r0 || bus.out_valid !== 1'b1) bp_stable = 1'b0;
                    if (bus.pixel_ready !== 1'b0) bp_prlow = 1'b0;
                end
                chk("bp_hold_stable",     32'(bp_stable), 32'd1);
                chk("bp_pixel_ready_low", 32'(bp_prlow),  32'd1);
                chk("bp_held_word",       bp_d0,          32'h4000_0000);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");

        // frame_start in the middle of row 1 discards the partial frame
        send_rows(8'h00, 8'h00, 1'b1, LW + 16, 1'b1, 1'b0);
        run_frame("restart_flat", 8'h80, 8'h80, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0);

        // reset mid-PROCESS, after the first word of row 1 has gone out
        sbq.push_back('{data: 32'h4000_0000, last: 1'b0, row: 10'd1});
        send_rows(8'h00, 8'h00, 1'b1, 3 * LW, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midproc_reset_out_valid",   32'(bus.out_valid),   32'd0);
        chk("midproc_reset_out_data",    bus.out_data,         32'd0);
        chk("midproc_reset_pixel_ready", 32'(bus.pixel_ready), 32'd0);
        chk("midproc_reset_words_left",  32'(sbq.size()),      32'd0);
`ifdef EDGE_SEQ_STATS_EN
        chk("midproc_reset_edge_count",  32'(bus.edge_count),  32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midproc_pixel_ready_after_reset", 32'(bus.pixel_ready), 32'd1);
        send_rows(8'hFF, 8'h00, 1'b0, 40, 1'b0, 1'b0);
        run_frame("after_reset_flat", 8'h80, 8'h80, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
